dfd_dbus_trace_capture: RTL and testbench
=========================================

# dfd_dbus_trace_capture

Trace capture stage that sits directly downstream of the debug bus mux select stage and consumes its `debug_bus` output. It samples the bus each cycle and records a word only on the first enabled cycle or when the bus changes (or on every cycle, depending on mode). Each recorded word is tagged with a 15-bit cycle delta and a gap marker and pushed into a small FIFO. The FIFO is drained through a valid/ready interface toward the trace sink, with overflow accounting.

## Interface
- `DEBUG_BUS_WIDTH`, 64: width of the sampled debug bus.
- `FIFO_DEPTH`, 8: entry count. Power of two, at least 2.
- `clk` in, 1: sole clock.
- `reset_n` in, 1: asynchronous, active-low reset.
- `debug_bus` in, DEBUG_BUS_WIDTH: bus from the mux select stage.
- `cap_en` in, 1: capture enable. Level signal.
- `cap_mode` in, 1: 0 = change-only capture, 1 = capture every enabled cycle.
- `cap_clr` in, 1: synchronous flush of the FIFO, counters and sticky status.
- `trc_valid` out, 1: FIFO head entry is valid.
- `trc_ready` in, 1: sink accepts the head entry.
- `trc_data` out, DEBUG_BUS_WIDTH+16: entry `{gap, delta[14:0], data}`.
- `trc_ovf` out, 1: sticky overflow flag.
- `trc_drop_cnt` out, 16: dropped-capture count, saturating at 0xFFFF.
- `fifo_level` out, $clog2(FIFO_DEPTH)+1: current entry count.

## Operation
- **Registers:** `last_q` (last captured bus value, width DEBUG_BUS_WIDTH), `first_q`, `delta_q[14:0]`, `gap_q`, FIFO memory, `rd_ptr`, `wr_ptr`, `count`, `trc_ovf`, `trc_drop_cnt`.
- **Capture event** (`cap`): `cap_en & (first_q | cap_mode | (debug_bus != last_q))`. The comparison uses the full bus width.
- **Delta:**
  - While `cap_en` is high and there is no `cap`: `delta_q <= sat(delta_q+1)`, saturating at 0x7FFF.
  - On `cap`: the entry's delta field is `delta_q`, then `delta_q <= 1`.
  - While `cap_en` is low: `delta_q <= 0` and `first_q <= 1`.
  - On `cap`: `first_q <= 0` and `last_q <= debug_bus`. This happens whether the push is accepted or dropped.
- **Push:** `push = cap & (~full | pop)`, where `full = (count == FIFO_DEPTH)` is evaluated on the pre-edge count.
  - When full and popping in the same cycle, the push is accepted and the count is unchanged.
  - The written entry is `{gap_q, delta, debug_bus}`.
- **Drop:** `cap & full & ~pop`.
  - Sets `trc_ovf` and `gap_q`.
  - Increments `trc_drop_cnt`, saturating.
  - The entry is lost. `delta_q` still resets to 1, so the delta of the next accepted entry is measured from the dropped capture.
- **Gap:** `gap_q` clears on the next accepted push. That entry carries gap = 1.
- **Pop:** `pop = trc_valid & trc_ready`.
  - `trc_valid = (count != 0)`.
  - `trc_data = mem[rd_ptr]`.
  - `trc_data` is stable while `trc_valid & ~trc_ready`.
- **Pointers:** wrap modulo FIFO_DEPTH. `count` changes by +1 (push only), −1 (pop only) or 0 (both or neither).
- **cap_clr:** has priority over everything.
  - `count`, both pointers, `trc_ovf`, `trc_drop_cnt`, `gap_q` and `delta_q` are set to 0; `first_q` is set to 1.
  - No push or pop occurs in that cycle. A `trc_ready` in that cycle is ignored.

## Timing
- **Reset values:** `trc_valid` 0, `trc_data` 0 (memory reset to 0), `trc_ovf` 0, `trc_drop_cnt` 0, `fifo_level` 0. Internally `first_q` 1, `delta_q` 0, `gap_q` 0, `last_q` 0.
- **Latency:** `debug_bus` value V sampled at edge N with `cap` set gives `trc_valid` = 1 and `trc_data[DEBUG_BUS_WIDTH-1:0]` = V after edge N, provided the FIFO was empty. This is one cycle of latency.
- **Throughput:** one push and one pop per cycle sustained.
- **Handshake:** the sink may hold `trc_ready` high continuously. `trc_valid` never depends combinationally on `trc_ready`.
- **cap_en falling:** entries already in the FIFO remain and drain normally.
- **Reset mid-operation:** asynchronous assertion clears all state immediately. Outputs take their reset values while `reset_n` is low.

## Test plan
- **Basic change capture:** reset, `cap_en`=1, mode 0, `trc_ready`=1. Drive bus 0x0 for 3 cycles, then 0xA5 for 2 cycles, then 0x0. Required: 3 entries, `{0,0,0x0}`, `{0,3,0xA5}`, `{0,2,0x0}`.
- **Every-cycle mode:** mode 1, 4 cycles of constant 0x1234. Required: 4 entries with deltas 0,1,1,1 and data 0x1234.
- **Overflow:** `trc_ready`=0, mode 1, 12 cycles with FIFO_DEPTH=8. Required: `fifo_level` 8, `trc_drop_cnt`=4, `trc_ovf`=1. After raising ready with one more capture, that entry has gap = 1 and delta = 1.
- **Full with simultaneous pop and push:** with the FIFO full, `trc_ready`=1 and a capture in the same cycle. Required: push accepted, level stays 8, no drop counted.
- **Delta saturation:** constant bus, mode 0, with 40000 cycles between changes. Required: entry delta = 0x7FFF.
- **Flush and async reset:** `cap_clr` mid-burst gives level 0 and ovf 0, and the next capture has delta 0. An asynchronous `reset_n` pulse between clock edges drops `trc_valid` to 0 immediately.

Source files
------------

// File: rtl/dfd_dbus_trace_capture_if.sv
// Debug-bus trace capture interface: sampled bus and capture controls on the
// upstream side, valid/ready drain plus overflow status toward the trace sink.
interface dfd_dbus_trace_capture_if #(
   parameter int DEBUG_BUS_WIDTH = 64,
   parameter int FIFO_DEPTH      = 8
);
   localparam int LW = $clog2(FIFO_DEPTH) + 1;

   logic [DEBUG_BUS_WIDTH-1:0]    debug_bus;
   logic                          cap_en;
   logic                          cap_mode;
   logic                          cap_clr;
   logic                          trc_valid;
   logic                          trc_ready;
   logic [DEBUG_BUS_WIDTH+15:0]   trc_data;
   logic                          trc_ovf;
   logic [15:0]                   trc_drop_cnt;
   logic [LW-1:0]                 fifo_level;

   // Driver side: mux stage, control and trace sink.
   modport master (
      output debug_bus, cap_en, cap_mode, cap_clr, trc_ready,
      input  trc_valid, trc_data, trc_ovf, trc_drop_cnt, fifo_level
   );

   // Capture block side.
   modport slave (
      input  debug_bus, cap_en, cap_mode, cap_clr, trc_ready,
      output trc_valid, trc_data, trc_ovf, trc_drop_cnt, fifo_level
   );
endinterface

// File: rtl/dfd_dbus_trace_capture.sv
// Debug-bus trace capture: records the bus on first enabled cycle, on change
// or every cycle, tags each word with {gap, delta} and buffers it in a FIFO
// drained by a valid/ready sink. Lost captures are counted and flagged.
module dfd_dbus_trace_capture #(
   parameter int DEBUG_BUS_WIDTH = 64,
   parameter int FIFO_DEPTH      = 8
) (
   input  logic                     clk,
   input  logic                     reset_n,
   dfd_dbus_trace_capture_if.slave  bus
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam int EW = DEBUG_BUS_WIDTH + 16;
   localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
   localparam logic [14:0]   DMAX    = 15'h7FFF;
   localparam logic [15:0]   CMAX    = 16'hFFFF;

   logic [DEBUG_BUS_WIDTH-1:0] last_q, last_d;
   logic                       first_q, first_d;
   logic [14:0]                delta_q, delta_d;
   logic                       gap_q, gap_d;
   logic                       ovf_q, ovf_d;
   logic [15:0]                drop_q, drop_d;
   logic [AW-1:0]              rd_ptr_q, rd_ptr_d;
   logic [AW-1:0]              wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]              count_q, count_d;
   logic [EW-1:0]              mem_q [FIFO_DEPTH];

   logic                       cap;
   logic                       full;
   logic                       pop;
   logic                       push;
   logic                       drop;
   logic [EW-1:0]              wr_entry;

   // Capture decision and FIFO traffic; a flush masks all push/pop/drop.
   always_comb begin
      cap      = bus.cap_en & (first_q | bus.cap_mode | (bus.debug_bus != last_q));
      full     = (count_q == DEPTH_C);
      pop      = (count_q != '0) & bus.trc_ready & ~bus.cap_clr;
      push     = cap & (~full | pop) & ~bus.cap_clr;
      drop     = cap & full & ~pop & ~bus.cap_clr;
      wr_entry = {gap_q, delta_q, bus.debug_bus};
   end

   // Next state for capture tracking, status and FIFO bookkeeping.
   always_comb begin
      last_d   = last_q;
      first_d  = first_q;
      delta_d  = delta_q;
      gap_d    = gap_q;
      ovf_d    = ovf_q;
      drop_d   = drop_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (bus.cap_clr) begin
         first_d  = 1'b1;
         delta_d  = '0;
         gap_d    = 1'b0;
         ovf_d    = 1'b0;
         drop_d   = '0;
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         // Delta restarts at 1 on any capture, even a dropped one, so the
         // next accepted entry is timed from the last observed change.
         if (!bus.cap_en) begin
            delta_d = '0;
            first_d = 1'b1;
         end else if (cap) begin
            delta_d = 15'd1;
            first_d = 1'b0;
            last_d  = bus.debug_bus;
         end else if (delta_q != DMAX) begin
            delta_d = delta_q + 15'd1;
         end
         if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
            gap_d    = 1'b0;
         end
         if (drop) begin
            gap_d = 1'b1;
            ovf_d = 1'b1;
            if (drop_q != CMAX) drop_d = drop_q + 16'd1;
         end
         if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
         case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // State registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         last_q   <= '0;
         first_q  <= 1'b1;
         delta_q  <= '0;
         gap_q    <= 1'b0;
         ovf_q    <= 1'b0;
         drop_q   <= '0;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         last_q   <= last_d;
         first_q  <= first_d;
         delta_q  <= delta_d;
         gap_q    <= gap_d;
         ovf_q    <= ovf_d;
         drop_q   <= drop_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   // Entry storage; cleared on reset so the idle head reads as zero.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      end else if (push) begin
         mem_q[wr_ptr_q] <= wr_entry;
      end
   end

   assign bus.trc_valid    = (count_q != '0);
   assign bus.trc_data     = mem_q[rd_ptr_q];
   assign bus.trc_ovf      = ovf_q;
   assign bus.trc_drop_cnt = drop_q;
   assign bus.fifo_level   = count_q;
endmodule

// File: tb/tb_dfd_dbus_trace_capture.sv
// Bench for the trace capture block: a queue-based reference model predicts
// every entry and status value; a monitor checks the sink handshake.
module tb_dfd_dbus_trace_capture;
   localparam int W  = 64;
   localparam int D  = 8;
   localparam int EW = W + 16;

   logic clk = 1'b0;
   logic reset_n = 1'b0;

   dfd_dbus_trace_capture_if #(.DEBUG_BUS_WIDTH(W), .FIFO_DEPTH(D)) tif ();

   dfd_dbus_trace_capture #(.DEBUG_BUS_WIDTH(W), .FIFO_DEPTH(D)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (tif)
   );

   always #5 clk = ~clk;

   int nvec = 0;
   int nerr = 0;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: sequence of events per clock, expected entries in sb.
   logic [EW-1:0] sb[$];
   logic [EW-1:0] popq[$];
   logic [W-1:0]  m_last = '0;
   bit            m_first = 1'b1;
   int            m_delta = 0;
   bit            m_gap = 1'b0;
   bit            m_ovf = 1'b0;
   int            m_drop = 0;
   int            m_lvl = 0;
   bit            m_c, m_p;

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_last = '0; m_first = 1; m_delta = 0; m_gap = 0;
         m_ovf = 0; m_drop = 0; m_lvl = 0; sb.delete();
      end else if (tif.cap_clr) begin
         m_first = 1; m_delta = 0; m_gap = 0;
         m_ovf = 0; m_drop = 0; m_lvl = 0; sb.delete();
      end else begin
         m_c = tif.cap_en && (m_first || tif.cap_mode || (tif.debug_bus != m_last));
         m_p = (m_lvl != 0) && tif.trc_ready;
         if (m_c) begin
            if (m_lvl < D || m_p) begin
               sb.push_back({m_gap, 15'(m_delta), tif.debug_bus});
               m_gap = 0;
               m_lvl++;
            end else begin
               m_ovf = 1;
               m_gap = 1;
               if (m_drop < 65535) m_drop++;
            end
            m_first = 0;
            m_last  = tif.debug_bus;
            m_delta = 1;
         end else if (tif.cap_en) begin
            m_delta = (m_delta < 32767) ? m_delta + 1 : 32767;
         end else begin
            m_delta = 0;
            m_first = 1;
         end
         if (m_p) m_lvl--;
      end
   end

   // Monitor: status every cycle, entry contents on each accepted pop.
   always @(negedge clk) begin
      if (reset_n) begin
         chk("level", 128'(tif.fifo_level), 128'(m_lvl));
         chk("valid", 128'(tif.trc_valid), 128'(m_lvl != 0));
         chk("ovf", 128'(tif.trc_ovf), 128'(m_ovf));
         chk("drop_cnt", 128'(tif.trc_drop_cnt), 128'(m_drop));
         if (tif.trc_valid && tif.trc_ready && !tif.cap_clr) begin
            popq.push_back(tif.trc_data);
            if (sb.size() == 0) begin
               chk("pop_unexpected", 128'(tif.trc_data), 128'bx);
            end else begin
               chk("entry", 128'(tif.trc_data), 128'(sb.pop_front()));
            end
         end
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   function automatic logic [EW-1:0] got(input int i);
      if (i < popq.size()) return popq[i];
      return 'x;
   endfunction

   logic [W-1:0] tbl [4];

   initial begin
      tbl[0] = 64'h0;
      tbl[1] = 64'h8000_0000_0000_0000;
      tbl[2] = 64'h0000_0000_0000_00A5;
      tbl[3] = 64'hDEAD_BEEF_0123_4567;
      tif.debug_bus = '0; tif.cap_en = 0; tif.cap_mode = 0;
      tif.cap_clr = 0; tif.trc_ready = 0;

      // Reset values.
      cyc(3);
      chk("rst_valid", 128'(tif.trc_valid), 128'(0));
      chk("rst_data", 128'(tif.trc_data), 128'(0));
      chk("rst_ovf", 128'(tif.trc_ovf), 128'(0));
      chk("rst_drop", 128'(tif.trc_drop_cnt), 128'(0));
      chk("rst_level", 128'(tif.fifo_level), 128'(0));
      reset_n = 1;
      cyc(1);

      // Change-only capture.
      popq.delete();
      tif.trc_ready = 1; tif.cap_en = 1; tif.cap_mode = 0;
      tif.debug_bus = 64'h0;  cyc(3);
      tif.debug_bus = 64'hA5; cyc(2);
      tif.debug_bus = 64'h0;  cyc(1);
      cyc(3);
      chk("basic_n", 128'(popq.size()), 128'(3));
      chk("basic_0", 128'(got(0)), 128'({1'b0, 15'd0, 64'h0}));
      chk("basic_1", 128'(got(1)), 128'({1'b0, 15'd3, 64'hA5}));
      chk("basic_2", 128'(got(2)), 128'({1'b0, 15'd2, 64'h0}));

      // Every-cycle capture.
      tif.cap_en = 0; cyc(1);
      popq.delete();
      tif.cap_mode = 1; tif.cap_en = 1; tif.debug_bus = 64'h1234; cyc(4);
      tif.cap_en = 0; cyc(3);
      chk("every_n", 128'(popq.size()), 128'(4));
      chk("every_0", 128'(got(0)), 128'({1'b0, 15'd0, 64'h1234}));
      chk("every_1", 128'(got(1)), 128'({1'b0, 15'd1, 64'h1234}));
      chk("every_3", 128'(got(3)), 128'({1'b0, 15'd1, 64'h1234}));

      // Overflow, then full with simultaneous pop and push.
      tif.trc_ready = 0; popq.delete();
      tif.cap_en = 1; tif.cap_mode = 1;
      for (int i = 0; i < 12; i++) begin
         tif.debug_bus = {32'($urandom), 32'($urandom)};
         cyc(1);
      end
      chk("ovf_level", 128'(tif.fifo_level), 128'(8));
      chk("ovf_drop", 128'(tif.trc_drop_cnt), 128'(4));
      chk("ovf_flag", 128'(tif.trc_ovf), 128'(1));
      tif.trc_ready = 1; tif.debug_bus = 64'h5555; cyc(1);
      chk("fullpp_level", 128'(tif.fifo_level), 128'(8));
      chk("fullpp_drop", 128'(tif.trc_drop_cnt), 128'(4));
      tif.cap_en = 0; cyc(10);
      chk("ovf_pops", 128'(popq.size()), 128'(9));
      chk("gap_entry", 128'(got(8)), 128'({1'b1, 15'd1, 64'h5555}));
      chk("ovf_sticky", 128'(tif.trc_ovf), 128'(1));

      // Flush mid-burst.
      tif.trc_ready = 0; tif.cap_en = 1; tif.cap_mode = 1; cyc(3);
      tif.cap_clr = 1; tif.trc_ready = 1; cyc(1);
      tif.cap_clr = 0;
      chk("clr_level", 128'(tif.fifo_level), 128'(0));
      chk("clr_ovf", 128'(tif.trc_ovf), 128'(0));
      chk("clr_drop", 128'(tif.trc_drop_cnt), 128'(0));
      popq.delete();
      tif.debug_bus = 64'h77; cyc(1);
      tif.cap_en = 0; cyc(2);
      chk("clr_next", 128'(got(0)), 128'({1'b0, 15'd0, 64'h77}));

      // Delta saturation.
      popq.delete();
      tif.cap_mode = 0; tif.debug_bus = 64'h5; tif.cap_en = 1; cyc(1);
      cyc(40000);
      tif.debug_bus = 64'h6; cyc(1);
      tif.cap_en = 0; cyc(3);
      chk("sat_n", 128'(popq.size()), 128'(2));
      chk("sat_entry", 128'(got(1)), 128'({1'b0, 15'h7FFF, 64'h6}));

      // Randomized traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         tif.cap_en    = ($urandom_range(0, 9) != 0);
         tif.cap_mode  = ($urandom_range(0, 3) == 0);
         tif.cap_clr   = ($urandom_range(0, 149) == 0);
         tif.trc_ready = ($urandom_range(0, 2) != 0) && (i % 200 > 40);
         if ($urandom_range(0, 2) == 0) tif.debug_bus = tbl[$urandom_range(0, 3)];
         cyc(1);
      end
      tif.cap_clr = 0; tif.cap_en = 0; tif.trc_ready = 1; cyc(10);

      // Asynchronous reset between edges.
      tif.trc_ready = 0; tif.cap_en = 1; tif.cap_mode = 1; cyc(3);
      tif.cap_en = 0;
      chk("pre_arst_valid", 128'(tif.trc_valid), 128'(1));
      #2 reset_n = 0;
      #1;
      chk("arst_valid", 128'(tif.trc_valid), 128'(0));
      chk("arst_level", 128'(tif.fifo_level), 128'(0));
      chk("arst_data", 128'(tif.trc_data), 128'(0));
      #2 reset_n = 1;
      cyc(3);
      chk("post_arst_level", 128'(tif.fifo_level), 128'(0));

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
